alu_add_sub_pipe: RTL and testbench

//  Parametrised, pipelined adder/subtractor for the ALU datapath, successor to the single-cycle 32-bit unit.

---
 rtl/alu_add_sub_pipe.sv | 110 +++++++++++
 tb/tb_alu_add_sub_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_add_sub_pipe.sv
// alu_add_sub_pipe: pipelined carry-lookahead adder/subtractor with valid/ready handshake and ALU flags
// Ports: clk; reset (async, active-low); in_valid/in_ready/a/b/sub/sign form the operand beat;
//        out_valid/out_ready/sum/zero/ovf/neg/lt form the result beat, held stable while stalled.
module alu_add_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             zero,
  output logic             ovf,
  output logic             neg,
  output logic             lt
);
  localparam int G = WIDTH / SEG / STAGES;
  localparam int L = STAGES - 1;
  logic [WIDTH-1:0] a_q [STAGES], b_q [STAGES], s_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES], b_d [STAGES], s_d [STAGES];
  logic c_q [STAGES], sub_q [STAGES], sign_q [STAGES];
  logic c_d [STAGES], sub_d [STAGES], sign_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES:0] rdy;
  logic zero_q, ovf_q, neg_q, lt_q, zero_d, ovf_d, neg_d, lt_d, c_msb;
  // One SEG-bit lookahead group: returns {carry out, sum bits}
  function automatic logic [SEG:0] cla(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
    logic [SEG-1:0] p, g;
    logic [SEG:0] c;
    p = x ^ y;
    g = x & y;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = L; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
    // Subtraction feeds ~b with the +1 entering as the carry-in of group 0
    v_d[0] = in_valid;
    a_d[0] = a;
    b_d[0] = sub ? ~b : b;
    s_d[0] = '0;
    c_d[0] = sub;
    sub_d[0] = sub;
    sign_d[0] = sign;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
      c_d[k] = c_q[k-1];
      sub_d[k] = sub_q[k-1];
      sign_d[k] = sign_q[k-1];
    end
    // c_d[k] enters as the stage carry-in and leaves as its carry-out
    for (int k = 0; k < STAGES; k++)
      for (int j = k * G; j < (k + 1) * G; j++)
        {c_d[k], s_d[k][j*SEG +: SEG]} = cla(a_d[k][j*SEG +: SEG], b_d[k][j*SEG +: SEG], c_d[k]);
    // Carry into the MSB recovered from the MSB sum bit
    c_msb = a_d[L][WIDTH-1] ^ b_d[L][WIDTH-1] ^ s_d[L][WIDTH-1];
    zero_d = s_d[L] == '0;
    ovf_d = sign_d[L] ? c_msb ^ c_d[L] : sub_d[L] ^ c_d[L];
    neg_d = sign_d[L] & s_d[L][WIDTH-1];
    lt_d = sub_d[L] & (sign_d[L] ? s_d[L][WIDTH-1] ^ c_msb ^ c_d[L] : ~c_d[L]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        sub_q[k] <= 1'b0;
        sign_q[k] <= 1'b0;
      end
      {zero_q, ovf_q, neg_q, lt_q} <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) v_q[k] <= v_d[k];
        // Payload loads only with a real beat so an empty pipeline keeps its last result
        if (rdy[k] & v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
          sub_q[k] <= sub_d[k];
          sign_q[k] <= sign_d[k];
        end
      end
      if (rdy[L] & v_d[L]) {zero_q, ovf_q, neg_q, lt_q} <= {zero_d, ovf_d, neg_d, lt_d};
    end
  end
  assign in_ready = rdy[0];
  assign out_valid = v_q[L];
  assign sum = s_q[L];
  assign zero = zero_q;
  assign ovf = ovf_q;
  assign neg = neg_q;
  assign lt = lt_q;
endmodule

// File: tb/tb_alu_add_sub_pipe.sv
// tb_alu_add_sub_pipe: scoreboard bench for the pipelined adder/subtractor at three sizes
module tb_alu_add_sub_pipe;
  typedef struct packed { logic [63:0] s; logic z, o, n, l; } exp_t;
  logic clk = 0, reset = 0;
  logic iv = 0, ir, ov, ordy = 1, sb = 0, sg = 0, zf, of, nf, lf;
  logic [31:0] a = 0, b = 0, s;
  logic sv = 0, ssb = 0, ssg = 0;
  logic [63:0] sa = 0, sbb = 0;
  logic ir1, ov1, zf1, of1, nf1, lf1, ir2, ov2, zf2, of2, nf2, lf2;
  logic [15:0] s1;
  logic [63:0] s2;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int checks = 0, errors = 0;

  alu_add_sub_pipe u0 (.clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .sub(sb), .sign(sg),
    .out_valid(ov), .out_ready(ordy), .sum(s), .zero(zf), .ovf(of), .neg(nf), .lt(lf));
  alu_add_sub_pipe #(.WIDTH(16), .SEG(4), .STAGES(1)) u1 (.clk(clk), .reset(reset), .in_valid(sv), .in_ready(ir1),
    .a(sa[15:0]), .b(sbb[15:0]), .sub(ssb), .sign(ssg), .out_valid(ov1), .out_ready(1'b1), .sum(s1), .zero(zf1),
    .ovf(of1), .neg(nf1), .lt(lf1));
  alu_add_sub_pipe #(.WIDTH(64), .SEG(4), .STAGES(4)) u2 (.clk(clk), .reset(reset), .in_valid(sv), .in_ready(ir2),
    .a(sa), .b(sbb), .sub(ssb), .sign(ssg), .out_valid(ov2), .out_ready(1'b1), .sum(s2), .zero(zf2),
    .ovf(of2), .neg(nf2), .lt(lf2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, range checks for overflow, comparisons for less-than
  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y, input logic su, input logic si);
    logic signed [66:0] one, h, m, ux, uy, sx, sy, t, ts;
    exp_t e;
    one = 67'sd1;
    h = one <<< (w - 1);
    m = (h <<< 1) - one;
    ux = $signed({3'b0, x}) & m;
    uy = $signed({3'b0, y}) & m;
    sx = ux >= h ? ux - (h <<< 1) : ux;
    sy = uy >= h ? uy - (h <<< 1) : uy;
    t = su ? ux - uy : ux + uy;
    ts = su ? sx - sy : sx + sy;
    e.s = 64'(t & m);
    e.z = e.s == '0;
    e.n = si & e.s[w-1];
    e.o = si ? (ts >= h || ts < -h) : (su ? ux < uy : t > m);
    e.l = su & (si ? sx < sy : ux < uy);
    return e;
  endfunction

  // Main DUT: occupancy-based in_ready check, then result/stall compare, then push on acceptance
  always @(negedge clk) if (reset) begin
    chk("in_ready", ir, 64'((q0.size() < 2) || ordy));
    if (ov) begin
      if (q0.size() == 0) chk("unexpected_beat", 64'(q0.size()), 1);
      else begin
        e0 = q0[0];
        chk(ordy ? "result" : "stall_hold", {zf, of, nf, lf, s}, {e0.z, e0.o, e0.n, e0.l, e0.s[31:0]});
        if (ordy) void'(q0.pop_front());
      end
    end
    if (iv && ir) q0.push_back(model(32, 64'(a), 64'(b), sb, sg));
  end

  always @(negedge clk) if (reset) begin
    if (ov1) begin
      if (q1.size() == 0) chk("unexpected16", 64'(q1.size()), 1);
      else begin
        e1 = q1.pop_front();
        chk("result16", {zf1, of1, nf1, lf1, s1}, {e1.z, e1.o, e1.n, e1.l, e1.s[15:0]});
      end
    end
    if (ov2) begin
      if (q2.size() == 0) chk("unexpected64", 64'(q2.size()), 1);
      else begin
        e2 = q2.pop_front();
        chk("result64_sum", s2, e2.s);
        chk("result64_flags", {zf2, of2, nf2, lf2}, {e2.z, e2.o, e2.n, e2.l});
      end
    end
    if (sv) begin
      chk("in_ready16", ir1, 1);
      chk("in_ready64", ir2, 1);
      q1.push_back(model(16, sa, sbb, ssb, ssg));
      q2.push_back(model(64, sa, sbb, ssb, ssg));
    end
  end

  task automatic rnd();
    a = $urandom;
    b = ($urandom_range(0, 7) == 0) ? a : $urandom;
    sb = 1'($urandom);
    sg = 1'($urandom);
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic su, input logic si);
    int n = 0;
    a = x;
    b = y;
    sb = su;
    sg = si;
    iv = 1;
    @(negedge clk);
    while (!ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir) chk("accept_timeout", 64'(n), 0);
    @(posedge clk);
    #1 iv = 0;
  endtask

  task automatic dir(input logic [31:0] x, input logic [31:0] y, input logic su, input logic si,
                     input logic [31:0] es, input logic [3:0] ef);
    int n = 1;
    ordy = 1;
    send(x, y, su, si);
    while (!ov && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 64'(n), 2);
    chk("dir_sum", s, es);
    chk("dir_flags", {zf, of, nf, lf}, ef);
    @(posedge clk);
    #1;
  endtask

  task automatic spat(input int w, input int c);
    logic [63:0] h;
    h = 64'd1 << (w - 1);
    case (c)
      0: {sa, sbb, ssb, ssg} = {64'd1, (h << 1) - 64'd1, 2'b00};
      1: {sa, sbb, ssb, ssg} = {h - 64'd1, 64'd1, 2'b01};
      2: {sa, sbb, ssb, ssg} = {h, 64'd1, 2'b11};
      3: {sa, sbb, ssb, ssg} = {64'd5, 64'd5, 2'b11};
      4: {sa, sbb, ssb, ssg} = {64'd3, 64'd5, 2'b10};
      default: {sa, sbb, ssb, ssg} = {64'd5, 64'd3, 2'b10};
    endcase
  endtask

  task automatic drain(input string nm);
    int n = 0;
    iv = 0;
    ordy = 1;
    while (q0.size() != 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk(nm, 64'(q0.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int acc;
    logic t;
    #1;
    chk("reset_state", {ov, s, zf, of, nf, lf}, 0);
    @(posedge clk);
    #1 reset = 1;
    chk("reset_in_ready", ir, 1);
    dir(32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 32'h0, 4'b1100);
    dir(32'h7FFF_FFFF, 32'h1, 0, 1, 32'h8000_0000, 4'b0110);
    dir(32'h8000_0000, 32'h1, 1, 1, 32'h7FFF_FFFF, 4'b0101);
    dir(32'd5, 32'd5, 1, 1, 32'h0, 4'b1000);
    dir(32'd3, 32'd5, 1, 0, 32'hFFFF_FFFE, 4'b0101);
    dir(32'd5, 32'd3, 1, 0, 32'h2, 4'b0000);
    // Six back-to-back beats with out_ready low for three cycles
    acc = 0;
    rnd();
    iv = 1;
    for (int i = 0; i < 30 && acc < 6; i++) begin
      ordy = !(i >= 2 && i <= 4);
      @(negedge clk);
      t = ir;
      @(posedge clk);
      #1;
      if (t) begin
        acc++;
        rnd();
      end
    end
    iv = 0;
    chk("bp_beats", 64'(acc), 6);
    drain("bp_drain");
    for (int i = 0; i < 400; i++) begin
      iv = $urandom_range(0, 3) != 0;
      rnd();
      ordy = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    drain("rand_drain");
    for (int w = 16; w <= 64; w += 48)
      for (int c = 0; c < 6; c++) begin
        spat(w, c);
        sv = 1;
        @(posedge clk);
        #1;
      end
    for (int i = 0; i < 60; i++) begin
      sv = 1'($urandom);
      sa = {$urandom, $urandom};
      sbb = ($urandom_range(0, 7) == 0) ? sa : {$urandom, $urandom};
      ssb = 1'($urandom);
      ssg = 1'($urandom);
      @(posedge clk);
      #1;
    end
    sv = 0;
    repeat (8) @(posedge clk);
    #1 chk("sweep_drain", 64'(q1.size() + q2.size()), 0);
    // Reset with two beats held in the pipeline
    ordy = 0;
    send($urandom, $urandom, 0, 0);
    send($urandom, $urandom, 1, 1);
    chk("pre_reset_valid", ov, 1);
    #2 reset = 0;
    q0.delete();
    q1.delete();
    q2.delete();
    #1 chk("reset_async", ov, 0);
    chk("reset_outputs", {s, zf, of, nf, lf}, 0);
    @(posedge clk);
    #1 reset = 1;
    ordy = 1;
    repeat (6) begin
      @(posedge clk);
      #1 chk("no_stale", ov, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
